// File: rtl/nios_sys_cpu_oci_pkg.sv
// Shared definitions for the OCI memory controller: FSM states and jdo field positions.
package nios_sys_cpu_oci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    JRD_WAIT,
    JRD_CAP,
    JWR,
    CRD_WAIT
  } oci_state_e;

  localparam int JDO_CLR_ERR   = 35;
  localparam int JDO_RD_GO     = 34;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios_sys_cpu_ociram_sp_ram.sv
// Single-port synchronous OCI RAM. Reads are registered (1 cycle), and a write
// returns the old word on q.
module nios_sys_cpu_ociram_sp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto a RAM macro; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      q_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/nios_sys_cpu_cpu_ocimem_ctrl.sv
// OCI memory controller: executes JTAG debug reads/writes into the OCI RAM and
// serves CPU monitor reads when JTAG is idle.
module nios_sys_cpu_cpu_ocimem_ctrl
  import nios_sys_cpu_oci_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic              cpu_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  oci_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_valid_q, cpu_valid_d;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;

  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic              any_strobe, multi_strobe;
  logic              unused_jdo;

  assign jdo_addr     = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata    = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign unused_jdo   = ^{jdo[37:36], jdo[2:0]};
  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b)
                      | (take_action_ocimem_a & take_no_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a);

  // JTAG strictly outranks the CPU; the CPU is stalled while in reset as well.
  assign cpu_waitrequest = ~reset_n | (state_q != IDLE) | any_strobe;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    ready_d     = ready_q;
    err_d       = err_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_valid_d = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = mon_a_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (take_action_ocimem_a) begin
          mon_a_d = jdo_addr;
          ready_d = 1'b0;
          if (jdo[JDO_CLR_ERR]) err_d = 1'b0;
          if (jdo[JDO_RD_GO]) begin
            ram_en   = 1'b1;
            ram_addr = jdo_addr;
            state_d  = JRD_WAIT;
          end
        end else if (take_action_ocimem_b) begin
          ram_en  = 1'b1;
          ram_we  = 1'b1;
          mon_d_d = jdo_wdata;
          ready_d = 1'b0;
          state_d = JWR;
        end else if (take_no_action_ocimem_a) begin
          ram_en  = 1'b1;
          ready_d = 1'b0;
          state_d = JRD_WAIT;
        end else if (cpu_read) begin
          ram_en   = 1'b1;
          ram_addr = cpu_address;
          state_d  = CRD_WAIT;
        end
        // Losing strobes are overruns; this wins over a same-cycle clear.
        if (multi_strobe) err_d = 1'b1;
      end
      JRD_WAIT: state_d = JRD_CAP;
      JRD_CAP: begin
        mon_d_d = ram_q;
        mon_a_d = mon_a_q + ADDR_ONE;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      JWR: begin
        mon_a_d = mon_a_q + ADDR_ONE;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      CRD_WAIT: begin
        cpu_rdata_d = ram_q;
        cpu_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && any_strobe) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_valid_q <= cpu_valid_d;
    end
  end

  // A command presented while reset_n is low must not reach the RAM.
  nios_sys_cpu_ociram_sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en & reset_n),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (jdo_wdata),
    .q_o     (ram_q)
  );

  assign MonDReg           = mon_d_q;
  assign monitor_ready     = ready_q;
  assign monitor_error     = err_q;
  assign cpu_readdata      = cpu_rdata_q;
  assign cpu_readdatavalid = cpu_valid_q;

endmodule

// File: tb/tb_nios_sys_cpu_cpu_ocimem_ctrl.sv
// Self-checking bench: directed scenarios plus random JTAG/CPU traffic against
// a transaction-level model (memory array, address pointer, data/error registers).
module tb_nios_sys_cpu_cpu_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic [31:0] cpu_readdata, MonDReg;
  logic        cpu_waitrequest, cpu_readdatavalid, monitor_ready, monitor_error;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  logic [7:0]  m_addr;
  logic [31:0] m_dreg;
  logic        m_err;

  nios_sys_cpu_cpu_ocimem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdatavalid       (cpu_readdatavalid),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] j = '0;
    j[35]    = clr;
    j[34]    = rd;
    j[24:17] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Present strobes for one cycle; called and returns at a negedge.
  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
    jdo                     = j;
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = na;
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  // Counts cycles from the strobe cycle until monitor_ready is seen high.
  task automatic wait_ready(input string tag, input int exp_lat, input int start);
    int lat = start;
    while (!monitor_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic op_check(input string tag);
    check({tag, "_mondreg"}, MonDReg, m_dreg);
    check({tag, "_err"}, {31'b0, monitor_error}, {31'b0, m_err});
  endtask

  task automatic do_load(input logic [7:0] addr, input logic rd, input logic clr, input string tag);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, rd, clr));
    m_addr = addr;
    if (clr) m_err = 1'b0;
    if (rd) begin
      m_dreg = m_mem[addr];
      m_addr = addr + 8'd1;
    end
    wait_ready(tag, rd ? 3 : 2, 1);
    op_check(tag);
  endtask

  task automatic do_write(input logic [31:0] d, input string tag);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(d));
    m_mem[m_addr] = d;
    m_dreg = d;
    m_addr = m_addr + 8'd1;
    wait_ready(tag, 2, 1);
    op_check(tag);
  endtask

  task automatic do_next(input string tag);
    pulse(1'b0, 1'b0, 1'b1, '0);
    m_dreg = m_mem[m_addr];
    m_addr = m_addr + 8'd1;
    wait_ready(tag, 3, 1);
    op_check(tag);
  endtask

  // Holds cpu_read until accepted, then expects exactly one valid pulse with the model word.
  task automatic cpu_rd(input logic [7:0] a, input string tag);
    int          waits  = 0;
    int          pulses = 0;
    logic [31:0] data   = '0;
    cpu_address = a;
    cpu_read    = 1'b1;
    #1;
    while (cpu_waitrequest && waits < 20) begin
      @(negedge clk);
      waits++;
      #1;
    end
    check({tag, "_accept"}, {31'b0, waits < 20}, 32'd1);
    @(negedge clk);
    cpu_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_readdatavalid) begin
        pulses++;
        data = cpu_readdata;
      end
      @(negedge clk);
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_data"}, data, m_mem[a]);
    op_check(tag);
  endtask

  initial begin
    logic [7:0] saved;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_read = 1'b0;
    cpu_address = '0;
    m_addr = '0;
    m_dreg = '0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, monitor_ready}, 32'd1);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_err", {31'b0, monitor_error}, 32'd0);
    check("rst_rdata", cpu_readdata, 32'h0);
    check("rst_valid", {31'b0, cpu_readdatavalid}, 32'd0);
    check("rst_waitreq", {31'b0, cpu_waitrequest}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill the whole RAM so every later read has a known expected word.
    do_load(8'h00, 1'b0, 1'b0, "fill_load");
    for (int i = 0; i < 256; i++) do_write($urandom, "fill");

    do_load(8'h10, 1'b0, 1'b0, "load10");
    do_write(32'hDEADBEEF, "wr_deadbeef");
    do_load(8'h10, 1'b1, 1'b0, "rd10");
    do_next("rd11");

    do_load(8'hFF, 1'b0, 1'b0, "loadff");
    do_write(32'h0000_0001, "wr_ff");
    do_next("wrap_rd00");
    do_next("wrap_rd01");
    do_load(8'hFF, 1'b1, 1'b0, "rdff");

    // Write issued while the read is still in flight must be dropped.
    saved = m_addr;
    pulse(1'b0, 1'b0, 1'b1, '0);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'hBAD0BAD0));
    m_dreg = m_mem[m_addr];
    m_addr = m_addr + 8'd1;
    m_err  = 1'b1;
    wait_ready("busy_rd", 3, 2);
    op_check("busy_rd");
    do_load(saved, 1'b1, 1'b1, "busy_clear");

    pulse(1'b1, 1'b1, 1'b1, jdo_a(8'h20, 1'b0, 1'b0));
    m_addr = 8'h20;
    m_err  = 1'b1;
    wait_ready("multi", 2, 1);
    op_check("multi");
    do_next("multi_rd20");
    do_load(8'h30, 1'b0, 1'b1, "multi_clear");

    // CPU read colliding with a JTAG load+read: JTAG goes first.
    cpu_address = 8'h10;
    cpu_read    = 1'b1;
    jdo = jdo_a(8'h10, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    #1;
    check("collide_waitreq", {31'b0, cpu_waitrequest}, 32'd1);
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    m_dreg = m_mem[8'h10];
    m_addr = 8'h11;
    cpu_rd(8'h10, "collide_cpu");
    check("collide_cpu_is_dead", m_mem[8'h10], 32'hDEADBEEF);
    do_next("after_collide_rd11");

    // Reset while the JTAG read is waiting on the RAM.
    pulse(1'b0, 1'b0, 1'b1, '0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'b0, monitor_ready}, 32'd1);
    check("midrst_mondreg", MonDReg, 32'h0);
    check("midrst_err", {31'b0, monitor_error}, 32'd0);
    check("midrst_waitreq", {31'b0, cpu_waitrequest}, 32'd1);
    reset_n = 1'b1;
    m_addr = '0;
    m_dreg = '0;
    m_err  = 1'b0;
    @(negedge clk);
    check("postrst_valid", {31'b0, cpu_readdatavalid}, 32'd0);
    do_next("postrst_rd00");

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0: do_load(8'($urandom), 1'b0, 1'($urandom), "rnd_load");
        1: do_load(8'($urandom), 1'b1, 1'($urandom), "rnd_loadrd");
        2: do_write($urandom, "rnd_write");
        3: do_next("rnd_next");
        default: cpu_rd(8'($urandom), "rnd_cpu");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios_sys_cpu_cpu_ocimem_ctrl.md
Name: nios_sys_cpu_cpu_ocimem_ctrl

Overview:
- Consumes the sysclk-domain debug-slave command strobes and the 38-bit `jdo` word.
- Executes JTAG host reads and writes into the on-chip debug RAM (OCI RAM).
- Returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave TCK stage for scan-out.
- Also serves word reads from the CPU debug monitor through a small Avalon-style port, arbitrated against JTAG traffic.

Parameters:
- ADDR_W, 8, OCI RAM word-address width (depth = 2^ADDR_W words).
- DATA_W, 32, RAM data width; fixed at 32 to match `MonDReg`.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- jdo  in  38  debug command/data word from the debug-slave sysclk stage.
- take_action_ocimem_a  in  1  one-cycle strobe: load address / control command.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read the next word at the current address.
- take_action_ocimem_b  in  1  one-cycle strobe: write data to the current address.
- cpu_address  in  ADDR_W  CPU monitor word address.
- cpu_read  in  1  CPU read request.
- cpu_readdata  out  32  CPU read data.
- cpu_waitrequest  out  1  CPU stall.
- cpu_readdatavalid  out  1  CPU read-data strobe.
- MonDReg  out  32  monitor data register.
- monitor_ready  out  1  last JTAG operation complete.
- monitor_error  out  1  sticky command-overrun flag.

Behaviour:
- Reset values: MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, cpu_readdata=0, cpu_readdatavalid=0, cpu_waitrequest=1, FSM=IDLE.
- Field map:
  - jdo[35]: clear error.
  - jdo[34]: read-after-load.
  - jdo[17+ADDR_W-1:17]: address.
  - jdo[34:3]: write data (ocimem_b only).
- FSM states: IDLE, JRD_WAIT, JRD_CAP, JWR, CRD_WAIT.
- IDLE, take_action_ocimem_a:
  - MonAReg <= address field; monitor_ready <= 0.
  - If jdo[35]=1, monitor_error <= 0.
  - If jdo[34]=1, issue a RAM read and go to JRD_WAIT; else monitor_ready <= 1 next cycle and stay in IDLE.
- IDLE, take_no_action_ocimem_a: issue a RAM read at MonAReg; monitor_ready <= 0; go to JRD_WAIT.
- JRD_WAIT (RAM latency, 1 cycle) -> JRD_CAP.
- JRD_CAP:
  - MonDReg <= RAM q.
  - MonAReg <= MonAReg+1, modulo 2^ADDR_W (wraps 0xFF->0x00 at default).
  - monitor_ready <= 1; go to IDLE.
  - Read-to-ready latency: 3 cycles after the strobe.
- IDLE, take_action_ocimem_b:
  - RAM write of jdo[34:3] at MonAReg; MonDReg <= written data; monitor_ready <= 0; go to JWR.
  - JWR: MonAReg++ (wrap), monitor_ready <= 1, go to IDLE. Write-to-ready latency: 2 cycles.
- Simultaneous strobes in one cycle: priority ocimem_a > ocimem_b > no_action_ocimem_a; the losers are dropped and monitor_error <= 1.
- Any strobe while FSM != IDLE: command dropped, monitor_error <= 1 (sticky). State and address are unaffected.
- CPU port:
  - cpu_waitrequest=0 only in IDLE with no JTAG strobe that cycle; JTAG has strict priority.
  - An accepted cpu_read issues a RAM read and goes to CRD_WAIT.
  - Next cycle: cpu_readdata <= q, cpu_readdatavalid=1 for exactly one cycle, back to IDLE.
  - The CPU path never touches MonDReg or MonAReg.
- reset_n low mid-operation: synchronous return to reset values on the next edge. An in-flight RAM write completes only if its write-enable edge was already sampled. No readdatavalid is issued for an aborted CPU read.

Decomposition:
- Package nios_sys_cpu_oci_pkg holds:
  - the FSM state enum;
  - jdo field localparams (JDO_CLR_ERR=35, JDO_RD_GO=34, JDO_ADDR_LSB=17, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3).
- Sub-module nios_sys_cpu_ociram_sp_ram:
  - single-port 2^ADDR_W x 32 synchronous RAM;
  - 1-cycle registered read;
  - write-first disabled, i.e. q holds the old data on a write.

Test Plan:
- Reset, then ocimem_b with data 0xDEADBEEF after loading address 0x10 (jdo[34]=0) -> RAM[0x10]=0xDEADBEEF; monitor_ready returns to 1 two cycles after the strobe; MonAReg=0x11.
- Load address 0x10 with jdo[34]=1 -> MonDReg=0xDEADBEEF and monitor_ready=1 three cycles after the strobe; MonAReg=0x11.
- Load address 0xFF, write 0x1, then no_action_ocimem_a -> MonAReg wraps to 0x00; the read returns RAM[0x00] and MonAReg becomes 0x01.
- no_action_ocimem_a, then ocimem_b one cycle later (FSM busy) -> monitor_error=1; the write is not performed; a later ocimem_a with jdo[35]=1 clears it.
- cpu_read at address 0x10 in the same cycle as an ocimem_a strobe -> cpu_waitrequest=1 that cycle; after JTAG completes, cpu_readdata=0xDEADBEEF with a single readdatavalid pulse.
- reset_n asserted during JRD_WAIT -> next cycle FSM=IDLE, monitor_ready=1, MonDReg=0, no error.
